// File: rtl/alu_share_arbiter.sv
// One combinational RISC-V style ALU shared by N_REQ requesters.
// A round-robin arbiter picks one requester per cycle. The ALU result and the
// requester ID go into a one-entry output register, which is drained through a
// valid/ready handshake.

// Combinational ALU. The encodings follow RISC-V funct3. arith_logic selects
// SUB instead of ADD and SRA instead of SRL.
module alu #(
  parameter int NB_WORD   = 32,
  parameter int NB_FUNCT3 = 3
) (
  input  logic [NB_WORD-1:0]   i_op1,
  input  logic [NB_WORD-1:0]   i_op2,
  input  logic [NB_FUNCT3-1:0] i_funct3,
  input  logic                 i_arith_logic,
  output logic [NB_WORD-1:0]   o_result
);
  localparam logic [NB_FUNCT3-1:0] F_ADD  = NB_FUNCT3'(0);
  localparam logic [NB_FUNCT3-1:0] F_SLL  = NB_FUNCT3'(1);
  localparam logic [NB_FUNCT3-1:0] F_SLT  = NB_FUNCT3'(2);
  localparam logic [NB_FUNCT3-1:0] F_SLTU = NB_FUNCT3'(3);
  localparam logic [NB_FUNCT3-1:0] F_XOR  = NB_FUNCT3'(4);
  localparam logic [NB_FUNCT3-1:0] F_SR   = NB_FUNCT3'(5);
  localparam logic [NB_FUNCT3-1:0] F_OR   = NB_FUNCT3'(6);
  localparam logic [NB_FUNCT3-1:0] F_AND  = NB_FUNCT3'(7);

  logic [4:0] shamt;
  assign shamt = i_op2[4:0];

  // Select the operation. Any code outside the table yields zero.
  always_comb begin
    o_result = '0;
    case (i_funct3)
      F_ADD:  o_result = i_arith_logic ? (i_op1 - i_op2) : (i_op1 + i_op2);
      F_SLL:  o_result = i_op1 << shamt;
      F_SLT:  o_result = {{(NB_WORD-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      F_SLTU: o_result = {{(NB_WORD-1){1'b0}}, (i_op1 < i_op2)};
      F_XOR:  o_result = i_op1 ^ i_op2;
      F_SR:   o_result = i_arith_logic ? NB_WORD'($signed(i_op1) >>> shamt)
                                       : (i_op1 >> shamt);
      F_OR:   o_result = i_op1 | i_op2;
      F_AND:  o_result = i_op1 & i_op2;
      default: o_result = '0;
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter int NB_WORD   = 32,
  parameter int NB_FUNCT3 = 3,
  parameter int N_REQ     = 2,
  parameter int NB_ID     = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*NB_WORD-1:0]   i_req_op1,
  input  logic [N_REQ*NB_WORD-1:0]   i_req_op2,
  input  logic [N_REQ*NB_FUNCT3-1:0] i_req_funct3,
  input  logic [N_REQ-1:0]           i_req_arith_logic,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [NB_WORD-1:0]         o_result,
  output logic [NB_ID-1:0]           o_id
);
  // Unpacked views of the packed request payloads.
  logic [NB_WORD-1:0]   op1_arr   [N_REQ];
  logic [NB_WORD-1:0]   op2_arr   [N_REQ];
  logic [NB_FUNCT3-1:0] funct3_arr[N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op1_arr[gi]    = i_req_op1[gi*NB_WORD +: NB_WORD];
      assign op2_arr[gi]    = i_req_op2[gi*NB_WORD +: NB_WORD];
      assign funct3_arr[gi] = i_req_funct3[gi*NB_FUNCT3 +: NB_FUNCT3];
    end
  endgenerate

  logic [NB_ID-1:0]   ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic [NB_WORD-1:0] result_q, result_d;
  logic [NB_ID-1:0]   id_q, id_d;

  logic               win_found;
  logic [NB_ID-1:0]   win_id;
  logic               can_accept;
  logic               accept;

  // Round-robin scan that starts at ptr and wraps modulo N_REQ. The first valid
  // requester wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && i_req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = NB_ID'(idx);
      end
    end
  end

  // The slot is free when it is empty or when it drains this cycle. Flush and
  // reset block acceptance outright, and ready never feeds back into itself.
  assign can_accept = !valid_q || i_ready;
  assign accept     = can_accept && win_found && !i_flush && !i_reset;

  // Set the ready bit of the winner only when the accept actually happens.
  always_comb begin
    o_req_ready = '0;
    if (accept) o_req_ready[win_id] = 1'b1;
  end

  logic [NB_WORD-1:0]   alu_op1, alu_op2, alu_result;
  logic [NB_FUNCT3-1:0] alu_funct3;
  logic                 alu_arith;

  // Route the winner's payload to the ALU. The ALU inputs are zero when there
  // is no winner, so they do not toggle needlessly.
  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_funct3 = '0;
    alu_arith  = 1'b0;
    if (win_found) begin
      alu_op1    = op1_arr[win_id];
      alu_op2    = op2_arr[win_id];
      alu_funct3 = funct3_arr[win_id];
      alu_arith  = i_req_arith_logic[win_id];
    end
  end

  alu #(
    .NB_WORD  (NB_WORD),
    .NB_FUNCT3(NB_FUNCT3)
  ) u_alu (
    .i_op1        (alu_op1),
    .i_op2        (alu_op2),
    .i_funct3     (alu_funct3),
    .i_arith_logic(alu_arith),
    .o_result     (alu_result)
  );

  // Next state of the output entry and the pointer. Flush beats accept, and
  // accept beats a plain drain.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = alu_result;
      id_d     = win_id;
      ptr_d    = (win_id == NB_ID'(N_REQ - 1)) ? '0 : win_id + NB_ID'(1);
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_id     = id_q;
endmodule
